hazard_scoreboard: RTL and testbench



---
 rtl/hazard_scoreboard.sv | 118 +++++++++++
 tb/tb_hazard_scoreboard.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Data-hazard scoreboard for the 5-stage pipeline: shadow EX/MEM/WB
// destinations, per-source forwarding selects, load-use and MDU stalls.
module hazard_scoreboard #(
    parameter int NUM_SRC   = 2,
    parameter int REG_AW    = 5,
    parameter int MDU_LAT   = 32,
    parameter int RF_BYPASS = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]        id_src_use,
    input  logic [REG_AW-1:0]         id_dst,
    input  logic [1:0]                id_kind,
    input  logic                      id_mdu_start,
    input  logic                      id_hilo_use,
    input  logic                      flush,
    output logic [NUM_SRC*3-1:0]      fwd_sel,
    output logic                      stall,
    output logic                      mdu_busy,
    output logic [REG_AW-1:0]         ex_dst,
    output logic [REG_AW-1:0]         mem_dst,
    output logic [REG_AW-1:0]         wb_dst
);

    localparam logic [1:0] K_LOAD = 2'd1;
    localparam logic [1:0] K_LINK = 2'd2;
    localparam int         CW     = $clog2(MDU_LAT + 1);

    logic [REG_AW-1:0] ex_dst_q, ex_dst_d;
    logic [1:0]        ex_kind_q, ex_kind_d;
    logic [REG_AW-1:0] mem_dst_q;
    logic [1:0]        mem_kind_q;
    // WB kind never changes a select, so only its destination is kept.
    logic [REG_AW-1:0] wb_dst_q;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [NUM_SRC-1:0] lu_vec;
    logic               load_use;
    logic               mdu_hazard;
    logic               accept;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [REG_AW-1:0] addr;
        logic              qual;
        logic              hit_ex;
        logic              hit_mem;
        logic              hit_wb;
        logic [2:0]        sel;

        assign addr    = id_src_addr[i*REG_AW +: REG_AW];
        assign qual    = id_src_use[i] && (addr != '0);
        assign hit_ex  = qual && (addr == ex_dst_q);
        assign hit_mem = qual && (addr == mem_dst_q);
        assign hit_wb  = qual && (addr == wb_dst_q);
        assign lu_vec[i] = hit_ex && (ex_kind_q == K_LOAD);

        // Nearest producer wins: EX, then MEM, then WB, else register file.
        always_comb begin
            sel = 3'd0;
            if (hit_ex) begin
                sel = (ex_kind_q == K_LINK) ? 3'd2 : 3'd1;
            end else if (hit_mem) begin
                if (mem_kind_q == K_LOAD)
                    sel = 3'd4;
                else if (mem_kind_q == K_LINK)
                    sel = 3'd5;
                else
                    sel = 3'd3;
            end else if (hit_wb) begin
                sel = (RF_BYPASS == 0) ? 3'd6 : 3'd0;
            end
        end

        assign fwd_sel[i*3 +: 3] = sel;
    end

    assign load_use   = |lu_vec;
    assign mdu_busy   = (cnt_q != '0);
    assign mdu_hazard = mdu_busy && (id_hilo_use || id_mdu_start);
    assign stall      = load_use || mdu_hazard;
    assign accept     = !stall && !flush;

    // Next EX entry and MDU countdown; stalled or flushed slots become bubbles.
    always_comb begin
        ex_dst_d  = accept ? id_dst : '0;
        ex_kind_d = accept ? id_kind : 2'd0;
        cnt_d     = cnt_q;
        if (id_mdu_start && accept)
            cnt_d = CW'(MDU_LAT);
        else if (cnt_q != '0)
            cnt_d = cnt_q - CW'(1);
    end

    // Advance the shadow pipeline and counter; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_dst_q   <= '0;
            ex_kind_q  <= 2'd0;
            mem_dst_q  <= '0;
            mem_kind_q <= 2'd0;
            wb_dst_q   <= '0;
            cnt_q      <= '0;
        end else begin
            ex_dst_q   <= ex_dst_d;
            ex_kind_q  <= ex_kind_d;
            mem_dst_q  <= ex_dst_q;
            mem_kind_q <= ex_kind_q;
            wb_dst_q   <= mem_dst_q;
            cnt_q      <= cnt_d;
        end
    end

    assign ex_dst  = ex_dst_q;
    assign mem_dst = mem_dst_q;
    assign wb_dst  = wb_dst_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: two 2-source instances that differ
// only in RF_BYPASS, plus a 3-source 6-bit instance.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] src;
    logic [1:0] use_v;
    logic [4:0] dst;
    logic [1:0] kind;
    logic       start, hilo, fl;

    logic [5:0] fwd_a, fwd_b;
    logic       stall_a, stall_b, busy_a, busy_b;
    logic [4:0] ex_a, mem_a, wb_a, ex_b, mem_b, wb_b;

    logic [17:0] c_src;
    logic [2:0]  c_use;
    logic [5:0]  c_dst;
    logic [1:0]  c_kind;
    logic        c_start, c_hilo, c_fl;
    logic [8:0]  fwd_c;
    logic        stall_c, busy_c;
    logic [5:0]  ex_c, mem_c, wb_c;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NUM_SRC(2), .REG_AW(5), .MDU_LAT(4), .RF_BYPASS(0)
    ) dut_a (
        .clk(clk), .rst(rst), .id_src_addr(src), .id_src_use(use_v),
        .id_dst(dst), .id_kind(kind), .id_mdu_start(start),
        .id_hilo_use(hilo), .flush(fl), .fwd_sel(fwd_a),
        .stall(stall_a), .mdu_busy(busy_a), .ex_dst(ex_a),
        .mem_dst(mem_a), .wb_dst(wb_a)
    );

    hazard_scoreboard #(
        .NUM_SRC(2), .REG_AW(5), .MDU_LAT(4), .RF_BYPASS(1)
    ) dut_b (
        .clk(clk), .rst(rst), .id_src_addr(src), .id_src_use(use_v),
        .id_dst(dst), .id_kind(kind), .id_mdu_start(start),
        .id_hilo_use(hilo), .flush(fl), .fwd_sel(fwd_b),
        .stall(stall_b), .mdu_busy(busy_b), .ex_dst(ex_b),
        .mem_dst(mem_b), .wb_dst(wb_b)
    );

    hazard_scoreboard #(
        .NUM_SRC(3), .REG_AW(6), .MDU_LAT(4), .RF_BYPASS(1)
    ) dut_c (
        .clk(clk), .rst(rst), .id_src_addr(c_src), .id_src_use(c_use),
        .id_dst(c_dst), .id_kind(c_kind), .id_mdu_start(c_start),
        .id_hilo_use(c_hilo), .flush(c_fl), .fwd_sel(fwd_c),
        .stall(stall_c), .mdu_busy(busy_c), .ex_dst(ex_c),
        .mem_dst(mem_c), .wb_dst(wb_c)
    );

    // Present one ID slot for dut_a/dut_b; outputs are settled 1 ns later.
    task automatic issue(input logic [4:0] s0, input logic u0,
                         input logic [4:0] s1, input logic u1,
                         input logic [4:0] d, input logic [1:0] k,
                         input logic st, input logic hl, input logic f);
        @(negedge clk);
        src   = {s1, s0};
        use_v = {u1, u0};
        dst   = d;
        kind  = k;
        start = st;
        hilo  = hl;
        fl    = f;
        #1;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++)
            issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        @(negedge clk);
        #1;
        checks++;
        if (stall_a !== 1'b0 || busy_a !== 1'b0 || fwd_a !== 6'd0) begin
            errors++;
            $display("FAIL reset_ctl got stall=%b busy=%b fwd=%h want 0 0 0",
                     stall_a, busy_a, fwd_a);
        end
        checks++;
        if ({ex_a, mem_a, wb_a} !== 15'd0) begin
            errors++;
            $display("FAIL reset_dst got %0d %0d %0d want 0 0 0",
                     ex_a, mem_a, wb_a);
        end
        checks++;
        if ({ex_c, mem_c, wb_c, fwd_c, stall_c, busy_c} !== 29'd0) begin
            errors++;
            $display("FAIL reset_c got ex=%0d mem=%0d wb=%0d fwd=%h want 0",
                     ex_c, mem_c, wb_c, fwd_c);
        end
    endtask

    task automatic test_alu_chain;
        nops(3);
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 2'd0, 1'b0, 1'b0, 1'b0);
        issue(5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 2'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (fwd_a[2:0] !== 3'd1 || stall_a !== 1'b0) begin
            errors++;
            $display("FAIL alu_ex got sel=%0d stall=%b want 1 0",
                     fwd_a[2:0], stall_a);
        end
        issue(5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (fwd_a[2:0] !== 3'd3) begin
            errors++;
            $display("FAIL alu_mem got %0d want 3", fwd_a[2:0]);
        end
        issue(5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (fwd_a[2:0] !== 3'd6) begin
            errors++;
            $display("FAIL alu_wb_nobypass got %0d want 6", fwd_a[2:0]);
        end
        checks++;
        if (fwd_b[2:0] !== 3'd0) begin
            errors++;
            $display("FAIL alu_wb_bypass got %0d want 0", fwd_b[2:0]);
        end
    endtask

    task automatic test_load_use;
        nops(3);
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 2'd1, 1'b0, 1'b0, 1'b0);
        issue(5'd0, 1'b0, 5'd5, 1'b1, 5'd8, 2'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (stall_a !== 1'b1 || fwd_a[5:3] !== 3'd1) begin
            errors++;
            $display("FAIL lu_stall got stall=%b sel=%0d want 1 1",
                     stall_a, fwd_a[5:3]);
        end
        issue(5'd0, 1'b0, 5'd5, 1'b1, 5'd8, 2'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (stall_a !== 1'b0 || fwd_a[5:3] !== 3'd4) begin
            errors++;
            $display("FAIL lu_mem got stall=%b sel=%0d want 0 4",
                     stall_a, fwd_a[5:3]);
        end
        checks++;
        if (ex_a !== 5'd0 || mem_a !== 5'd5) begin
            errors++;
            $display("FAIL lu_bubble got ex=%0d mem=%0d want 0 5",
                     ex_a, mem_a);
        end
    endtask

    task automatic test_link_zero;
        nops(3);
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd31, 2'd2, 1'b0, 1'b0, 1'b0);
        issue(5'd31, 1'b1, 5'd0, 1'b1, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (fwd_a[2:0] !== 3'd2) begin
            errors++;
            $display("FAIL link_ex got %0d want 2", fwd_a[2:0]);
        end
        checks++;
        if (fwd_a[5:3] !== 3'd0) begin
            errors++;
            $display("FAIL zero_src got %0d want 0", fwd_a[5:3]);
        end
        issue(5'd31, 1'b1, 5'd31, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (fwd_a[2:0] !== 3'd5) begin
            errors++;
            $display("FAIL link_mem got %0d want 5", fwd_a[2:0]);
        end
        checks++;
        if (fwd_a[5:3] !== 3'd0) begin
            errors++;
            $display("FAIL unused_src got %0d want 0", fwd_a[5:3]);
        end
    endtask

    task automatic test_mdu;
        nops(3);
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (busy_a !== 1'b0 || stall_a !== 1'b0) begin
            errors++;
            $display("FAIL mdu_idle got busy=%b stall=%b want 0 0",
                     busy_a, stall_a);
        end
        for (int c = 0; c < 4; c++) begin
            issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 2'd0, 1'b0, 1'b1, 1'b0);
            checks++;
            if (busy_a !== 1'b1 || stall_a !== 1'b1) begin
                errors++;
                $display("FAIL mfhi_wait%0d got busy=%b stall=%b want 1 1",
                         c, busy_a, stall_a);
            end
        end
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 2'd0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (busy_a !== 1'b0 || stall_a !== 1'b0 || ex_a !== 5'd0) begin
            errors++;
            $display("FAIL mfhi_go got busy=%b stall=%b ex=%0d want 0 0 0",
                     busy_a, stall_a, ex_a);
        end
        nops(1);
        checks++;
        if (ex_a !== 5'd7) begin
            errors++;
            $display("FAIL mfhi_ex got %0d want 7", ex_a);
        end
    endtask

    task automatic test_back_to_back;
        nops(1);
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        nops(1);
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (stall_a !== 1'b1) begin
            errors++;
            $display("FAIL start_busy got stall=%b want 1", stall_a);
        end
        nops(2);
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL count_last got busy=%b want 1", busy_a);
        end
        nops(1);
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL no_reload got busy=%b want 0", busy_a);
        end
    endtask

    task automatic test_flush_overlap;
        nops(3);
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 2'd1, 1'b0, 1'b0, 1'b0);
        issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd8, 2'd0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (stall_a !== 1'b1) begin
            errors++;
            $display("FAIL flush_lu_stall got %b want 1", stall_a);
        end
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 2'd0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (ex_a !== 5'd0 || mem_a !== 5'd5 || stall_a !== 1'b0) begin
            errors++;
            $display("FAIL flush_lu got ex=%0d mem=%0d stall=%b want 0 5 0",
                     ex_a, mem_a, stall_a);
        end
        nops(1);
        checks++;
        if (ex_a !== 5'd0) begin
            errors++;
            $display("FAIL flush_alu got ex=%0d want 0", ex_a);
        end
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 2'd1, 1'b0, 1'b0, 1'b0);
        issue(5'd6, 1'b1, 5'd0, 1'b0, 5'd2, 2'd0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (stall_a !== 1'b1 || busy_a !== 1'b1 || ex_a !== 5'd6) begin
            errors++;
            $display("FAIL pre_rst got stall=%b busy=%b ex=%0d want 1 1 6",
                     stall_a, busy_a, ex_a);
        end
        rst = 1'b1;
        issue(5'd6, 1'b1, 5'd0, 1'b0, 5'd2, 2'd0, 1'b1, 1'b1, 1'b1);
        rst = 1'b0;
        issue(5'd6, 1'b1, 5'd0, 1'b0, 5'd2, 2'd0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (busy_a !== 1'b0 || stall_a !== 1'b0) begin
            errors++;
            $display("FAIL rst_ctl got busy=%b stall=%b want 0 0",
                     busy_a, stall_a);
        end
        checks++;
        if ({ex_a, mem_a, wb_a} !== 15'd0 || fwd_a !== 6'd0) begin
            errors++;
            $display("FAIL rst_dst got %0d %0d %0d fwd=%h want 0",
                     ex_a, mem_a, wb_a, fwd_a);
        end
    endtask

    task automatic test_three_src;
        @(negedge clk);
        c_dst  = 6'd40;
        c_kind = 2'd1;
        @(negedge clk);
        c_dst  = 6'd0;
        c_kind = 2'd0;
        @(negedge clk);
        c_src = {6'd40, 6'd0, 6'd40};
        c_use = 3'b110;
        #1;
        checks++;
        if (fwd_c[8:6] !== 3'd4 || stall_c !== 1'b0) begin
            errors++;
            $display("FAIL c_src2 got sel=%0d stall=%b want 4 0",
                     fwd_c[8:6], stall_c);
        end
        checks++;
        if (fwd_c[5:0] !== 6'd0) begin
            errors++;
            $display("FAIL c_src01 got %h want 0", fwd_c[5:0]);
        end
        @(negedge clk);
        c_src = '0;
        c_use = '0;
    endtask

    initial begin
        rst   = 1'b1;
        src   = '0;
        use_v = '0;
        dst   = '0;
        kind  = '0;
        start = 1'b0;
        hilo  = 1'b0;
        fl    = 1'b0;
        c_src = '0;
        c_use = '0;
        c_dst = '0;
        c_kind = '0;
        c_start = 1'b0;
        c_hilo = 1'b0;
        c_fl = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_alu_chain();
        test_load_use();
        test_link_zero();
        test_mdu();
        test_back_to_back();
        test_flush_overlap();
        test_three_src();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
